// File: rtl/hum_controller_if.sv
// Sample/command bundle between the humidity sensor front end and hum_controller.
// The slave side consumes samples and drives the status display and actuator enables.
interface hum_controller_if;
    logic       hum_valid;
    logic [7:0] hum_value;
    logic [7:0] setpoint;
    logic [3:0] band;
    logic [1:0] status;
    logic       humidifier_on;
    logic       dehumidifier_on;

    modport master (
        output hum_valid, hum_value, setpoint, band,
        input  status, humidifier_on, dehumidifier_on
    );

    modport slave (
        input  hum_valid, hum_value, setpoint, band,
        output status, humidifier_on, dehumidifier_on
    );
endinterface

// File: rtl/hum_controller.sv
// Greenhouse humidity sequencer: hysteresis around a setpoint, minimum actuator
// run time, sensor timeout and out-of-range detection.
module hum_controller #(
    parameter int TICK_DIV      = 50_000_000,
    parameter int MIN_RUN_TICKS = 30,
    parameter int TIMEOUT_TICKS = 10,
    parameter int MAX_HUM       = 100
) (
    input logic        clk,
    input logic        reset,
    hum_controller_if.slave bus
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int RW = $clog2(MIN_RUN_TICKS + 1);
    localparam int OW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [8:0] MAX9 = 9'(MAX_HUM);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        HUMIDIFY   = 2'b01,
        DEHUMIDIFY = 2'b10,
        ERROR      = 2'b11
    } state_t;

    state_t        state, nxt;
    logic [TW-1:0] tick_cnt;
    logic [RW-1:0] run_cnt;
    logic [OW-1:0] tout_cnt;
    logic          tick, bad, run_done, expire, entering;
    logic [8:0]    hv, sp_raw, sp, lo, hi, sum;

    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // 9-bit thresholds; setpoint clamped so hi never exceeds the legal range
    assign hv     = {1'b0, bus.hum_value};
    assign sp_raw = {1'b0, bus.setpoint};
    assign sp     = (sp_raw > MAX9) ? MAX9 : sp_raw;
    assign lo     = (sp > {5'd0, bus.band}) ? sp - {5'd0, bus.band} : 9'd0;
    assign sum    = sp + {5'd0, bus.band};
    assign hi     = (sum > MAX9) ? MAX9 : sum;

    assign bad      = (hv > MAX9);
    assign run_done = (run_cnt >= RW'(MIN_RUN_TICKS));
    // only the tick that reaches the limit raises ERROR; the held value does not re-fire
    assign expire   = tick && (tout_cnt == OW'(TIMEOUT_TICKS - 1));

    always_comb begin
        nxt = state;
        if (bus.hum_valid) begin
            if (bad) nxt = ERROR;
            else begin
                case (state)
                    IDLE: begin
                        if (hv < lo)      nxt = HUMIDIFY;
                        else if (hv > hi) nxt = DEHUMIDIFY;
                    end
                    HUMIDIFY:   if (run_done && hv >= sp) nxt = IDLE;
                    DEHUMIDIFY: if (run_done && hv <= sp) nxt = IDLE;
                    default:    nxt = IDLE;
                endcase
            end
        end else if (expire) begin
            nxt = ERROR;
        end
    end

    assign entering = (nxt != state) && (nxt == HUMIDIFY || nxt == DEHUMIDIFY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            bus.humidifier_on   <= 1'b0;
            bus.dehumidifier_on <= 1'b0;
        end else begin
            state               <= nxt;
            bus.humidifier_on   <= (nxt == HUMIDIFY);
            bus.dehumidifier_on <= (nxt == DEHUMIDIFY);
        end
    end

    assign bus.status = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                 run_cnt <= '0;
        else if (entering)         run_cnt <= '0;
        else if (tick && !run_done) run_cnt <= run_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)              tout_cnt <= '0;
        else if (bus.hum_valid) tout_cnt <= '0;
        else if (tick && tout_cnt != OW'(TIMEOUT_TICKS)) tout_cnt <= tout_cnt + 1'b1;
    end
endmodule
